// File: rtl/tspi_arbiter.sv
// tspi_arbiter: two-requester round-robin arbiter driving a mode-0 TSPI master
module tspi_arbiter #(
    parameter int ClkDiv = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0][1:0]  len_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       done_o,
    output logic [31:0]      rdata_o,
    output logic             busy_o,
    output logic             tspi_clk_o,
    output logic             tspi_mosi_o,
    input  logic             tspi_miso_i,
    output logic             tspi_cs_no
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_div;
    logic [4:0]  r_bit;
    logic [1:0]  r_len;
    logic [31:0] r_tx, r_rx, r_rdata;
    logic        r_clk, r_last, r_id;
    logic [1:0]  w_gnt;
    logic        w_div_end, w_last_bit, w_cs;
    assign w_div_end   = r_div == 8'(ClkDiv - 1);
    assign w_last_bit  = r_bit == {r_len, 3'b111};
    assign w_cs        = r_state == SETUP || r_state == SHIFT || r_state == HOLD;
    assign gnt_o       = w_gnt;
    assign done_o      = (r_state == GAP && r_div == 8'd0) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o     = r_rdata;
    assign busy_o      = r_state != IDLE;
    assign tspi_clk_o  = r_clk;
    assign tspi_mosi_o = w_cs & r_tx[31];
    assign tspi_cs_no  = ~w_cs;
    // grant selection (round-robin on collision) and phase sequencing on divider wrap
    always_comb begin
        w_gnt  = 2'b00;
        w_next = r_state;
        if (r_state == IDLE && !rst_i)
            w_gnt = (req_i == 2'b11) ? (r_last ? 2'b01 : 2'b10) : req_i;
        case (r_state)
            IDLE:    w_next = (|w_gnt) ? SETUP : IDLE;
            SETUP:   w_next = w_div_end ? SHIFT : SETUP;
            SHIFT:   w_next = (w_div_end && r_clk && w_last_bit) ? HOLD : SHIFT;
            HOLD:    w_next = w_div_end ? GAP : HOLD;
            GAP:     w_next = w_div_end ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
    end
    // frame state: latch request at grant, shift on TSPI edges, publish rx at end of HOLD
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_div   <= 8'd0;
            r_bit   <= 5'd0;
            r_len   <= 2'd0;
            r_tx    <= 32'd0;
            r_rx    <= 32'd0;
            r_rdata <= 32'd0;
            r_clk   <= 1'b0;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_div   <= (r_state == IDLE || w_div_end) ? 8'd0 : r_div + 8'd1;
            if (|w_gnt) begin
                r_id   <= w_gnt[1];
                r_last <= w_gnt[1];
                r_len  <= len_i[w_gnt[1]];
                r_tx   <= wdata_i[w_gnt[1]] << {~len_i[w_gnt[1]], 3'b000};
                r_rx   <= 32'd0;
                r_bit  <= 5'd0;
            end
            if (r_state == SHIFT && w_div_end) begin
                r_clk <= ~r_clk;
                if (!r_clk)
                    r_rx <= {r_rx[30:0], tspi_miso_i};
                else begin
                    r_bit <= r_bit + 5'd1;
                    r_tx  <= r_tx << 1;
                end
            end
            if (r_state == HOLD && w_div_end)
                r_rdata <= r_rx;
        end
    end
endmodule

// File: tb/tb_tspi_arbiter.sv
// tb_tspi_arbiter: directed table-driven bench for tspi_arbiter with ClkDiv=2
module tb_tspi_arbiter;
    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       req_i = 2'b00;
    logic [1:0][1:0]  len_i = '0;
    logic [1:0][31:0] wdata_i = '0;
    logic [1:0]       gnt_o, done_o;
    logic [31:0]      rdata_o;
    logic             busy_o, tspi_clk_o, tspi_mosi_o, tspi_miso_i, tspi_cs_no;
    logic [1:0]       miso_mode = 2'd0;
    int passed = 0;
    int total = 0;
    int edges = 0;
    int gnt_cnt = 0;
    int done_cnt = 0;
    logic [31:0] cap = 32'd0;
    logic prev_clk = 1'b0;

    tspi_arbiter #(.ClkDiv(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .len_i(len_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .tspi_clk_o(tspi_clk_o), .tspi_mosi_o(tspi_mosi_o), .tspi_miso_i(tspi_miso_i),
        .tspi_cs_no(tspi_cs_no)
    );

    always #5 clk_i = ~clk_i;
    // slave model: 0 loops mosi back, 1 drives ones, 2 drives zeros
    assign tspi_miso_i = (miso_mode == 2'd0) ? tspi_mosi_o : (miso_mode == 2'd1);

    // observe TSPI rising edges and grant/done pulses away from the clk edge
    always @(negedge clk_i) begin
        if (tspi_clk_o && !prev_clk) begin
            edges <= edges + 1;
            cap   <= {cap[30:0], tspi_mosi_o};
        end
        prev_clk <= tspi_clk_o;
        if (gnt_o != 2'b00) gnt_cnt <= gnt_cnt + 1;
        if (done_o != 2'b00) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  len0, len1;
        logic [31:0] wd0, wd1;
        logic [1:0]  miso;
        logic [1:0]  gnt;
        int          cyc;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_gnt(input string nm, input logic [1:0] exp_gnt, input int exp_cyc);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt_o == 2'b00 && cyc < 300);
        chk({nm, "_cyc"}, cyc, exp_cyc);
        chk({nm, "_gnt"}, {30'd0, gnt_o}, {30'd0, exp_gnt});
    endtask

    task automatic wait_idle(input string nm);
        int cyc;
        cyc = 0;
        while (busy_o && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({nm, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, eb, gb, n;
        logic [31:0] wd, mask;
        string p;
        p = $sformatf("v%0d", idx);
        len_i = {v.len1, v.len0};
        wdata_i = {v.wd1, v.wd0};
        miso_mode = v.miso;
        req_i = v.req;
        #1;
        chk({p, "_gnt"}, {30'd0, gnt_o}, {30'd0, v.gnt});
        wd = v.gnt[1] ? v.wd1 : v.wd0;
        n = 8 * (int'(v.gnt[1] ? v.len1 : v.len0) + 1);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        @(posedge clk_i);
        #1;
        req_i = 2'b00;
        len_i = ~len_i;
        wdata_i = ~wdata_i;
        eb = edges;
        gb = gnt_cnt;
        cyc = 1;
        tick();
        while (done_o == 2'b00 && cyc < 400) begin
            if (cyc == 10) req_i = ~v.gnt;
            if (cyc == 12) req_i = 2'b00;
            tick();
            cyc++;
        end
        chk({p, "_done_cyc"}, cyc, v.cyc);
        chk({p, "_done"}, {30'd0, done_o}, {30'd0, v.gnt});
        chk({p, "_rdata"}, rdata_o, v.rdata);
        chk({p, "_cs_gap"}, {31'd0, tspi_cs_no}, 32'd1);
        chk({p, "_edges"}, edges - eb, n);
        chk({p, "_mosi"}, cap & mask, wd & mask);
        tick();
        tick();
        chk({p, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        chk({p, "_no_extra_gnt"}, gnt_cnt - gb, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int eb, db, cyc;
        vecs[0] = '{req: 2'b01, len0: 2'd0, len1: 2'd0, wd0: 32'h0000_00A5, wd1: 32'h0, miso: 2'd0, gnt: 2'b01, cyc: 37, rdata: 32'h0000_00A5};
        vecs[1] = '{req: 2'b10, len0: 2'd0, len1: 2'd3, wd0: 32'h0, wd1: 32'h1234_5678, miso: 2'd1, gnt: 2'b10, cyc: 133, rdata: 32'hFFFF_FFFF};
        vecs[2] = '{req: 2'b11, len0: 2'd1, len1: 2'd0, wd0: 32'h0000_BEEF, wd1: 32'h11, miso: 2'd0, gnt: 2'b01, cyc: 69, rdata: 32'h0000_BEEF};
        vecs[3] = '{req: 2'b11, len0: 2'd0, len1: 2'd2, wd0: 32'h22, wd1: 32'h00C3_5A7E, miso: 2'd0, gnt: 2'b10, cyc: 101, rdata: 32'h00C3_5A7E};
        vecs[4] = '{req: 2'b01, len0: 2'd0, len1: 2'd0, wd0: 32'hFFFF_FF3C, wd1: 32'h0, miso: 2'd2, gnt: 2'b01, cyc: 37, rdata: 32'h0};
        vecs[5] = '{req: 2'b10, len0: 2'd0, len1: 2'd0, wd0: 32'h0, wd1: 32'h0000_0081, miso: 2'd0, gnt: 2'b10, cyc: 37, rdata: 32'h0000_0081};

        req_i = 2'b01;
        tick();
        tick();
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_done", {30'd0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_cs", {31'd0, tspi_cs_no}, 32'd1);
        chk("rst_clk", {31'd0, tspi_clk_o}, 32'd0);
        chk("rst_mosi", {31'd0, tspi_mosi_o}, 32'd0);
        req_i = 2'b00;
        rst_i = 1'b0;
        tick();

        req_i = 2'b11;
        #1;
        chk("rr_first_gnt", {30'd0, gnt_o}, 32'd1);
        wait_gnt("rr_second", 2'b10, 39);
        wait_gnt("rr_third", 2'b01, 39);
        @(posedge clk_i);
        #1;
        req_i = 2'b00;
        wait_idle("rr");
        tick();

        req_i = 2'b10;
        #1;
        chk("r1_first_gnt", {30'd0, gnt_o}, 32'd2);
        wait_gnt("r1_second", 2'b10, 39);
        @(posedge clk_i);
        #1;
        req_i = 2'b00;
        wait_idle("r1");
        tick();

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        miso_mode = 2'd0;
        len_i = '0;
        wdata_i = {32'h0, 32'h0000_00FF};
        req_i = 2'b01;
        @(posedge clk_i);
        #1;
        req_i = 2'b00;
        eb = edges;
        cyc = 0;
        while (edges - eb < 5 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("abort_reach_bit5", edges - eb, 5);
        @(posedge clk_i);
        #1;
        chk("abort_clk_high_before", {31'd0, tspi_clk_o}, 32'd1);
        db = done_cnt;
        rst_i = 1'b1;
        #1;
        chk("abort_cs", {31'd0, tspi_cs_no}, 32'd1);
        chk("abort_clk", {31'd0, tspi_clk_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        chk("abort_no_done", done_cnt - db, 0);
        chk("abort_rdata", rdata_o, 32'd0);
        run_vec(vecs[0], 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tspi_arbiter.md
TSPI_ARBITER -- requirements
Module: tspi_arbiter

Interface
REQ-001 Parameter ClkDiv, default 4, meaning TSPI clock half-period in clk_i cycles; legal values are 1 to 255.
REQ-002 Port clk_i, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 Port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port req_i, input, 2 bits: per-requester frame request, level-held until granted.
REQ-005 Port len_i, input, 2x2 bits: per-requester frame length, encoded as bytes minus 1 (0 to 3).
REQ-006 Port wdata_i, input, 2x32 bits: per-requester transmit data, right-justified.
REQ-007 Port gnt_o, output, 2 bits: one-cycle accept pulse per requester.
REQ-008 Port done_o, output, 2 bits: one-cycle frame-complete pulse per requester.
REQ-009 Port rdata_o, output, 32 bits: received data, shared by both requesters, right-justified.
REQ-010 Port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 Ports tspi_clk_o (output, 1), tspi_mosi_o (output, 1), tspi_miso_i (input, 1) and tspi_cs_no (output, 1, active-low) form the TSPI pins.

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP, with a divider counter 0..ClkDiv-1 and a bit counter 0..31.
REQ-013 In IDLE, gnt_o SHALL be combinational from req_i.
- Only one request high: grant that requester.
- Both high: grant the requester not served last (rr pointer).
REQ-014 At a grant, len_i, wdata_i and the requester ID SHALL be latched and the rr pointer updated; next state is SETUP.
REQ-015 Frame length N = 8*(len+1) bits; bits wdata[N-1:0] SHALL be transmitted MSB-first.
REQ-016 SETUP: tspi_cs_no=0, tspi_clk_o=0, tspi_mosi_o=first bit; lasts ClkDiv cycles.
REQ-017 SHIFT: tspi_clk_o SHALL toggle every ClkDiv cycles, starting low, for exactly N rising and N falling edges (2*N*ClkDiv cycles).
- Rising edge: sample tspi_miso_i.
- Falling edge: present the next mosi bit (mode 0).
REQ-018 HOLD: tspi_cs_no=0, tspi_clk_o=0; lasts ClkDiv cycles, then the FSM enters GAP.
REQ-019 GAP: tspi_cs_no=1; lasts ClkDiv cycles, then the FSM returns to IDLE.
REQ-020 done_o[id] SHALL pulse in the first GAP cycle, i.e. 1+(2N+2)*ClkDiv cycles after the gnt_o cycle.
REQ-021 rdata_o SHALL hold the N sampled bits MSB-first in rdata[N-1:0], with upper bits zero.
- Valid from the done_o cycle until the next grant.
- Bits SHALL be shifted into an internal register and copied to rdata_o at done_o.
REQ-022 Requests outside IDLE SHALL be ignored (no gnt_o); a request withdrawn before IDLE SHALL never be granted.
REQ-023 A new grant SHALL NOT occur before GAP completes; at most one gnt_o bit and one done_o bit is high per cycle.
REQ-024 len_i and wdata_i changes after the grant SHALL NOT affect the frame in flight.
REQ-025 With ClkDiv=1, tspi_clk_o SHALL toggle every cycle and the timing of REQ-020 SHALL still hold.

Reset
REQ-026 While rst_i=1 (asynchronous), the block SHALL force:
- state=IDLE, counters=0, rr pointer favouring requester 0;
- tspi_cs_no=1, tspi_clk_o=0, tspi_mosi_o=0;
- gnt_o=0, done_o=0, rdata_o=0, busy_o=0.
REQ-027 Reset during any frame SHALL abort it with no done_o pulse; the first cycle after release SHALL be IDLE.

Verification (ClkDiv=2)
REQ-028 req_i=01, len=0, wdata=0xA5, miso looped to mosi -> gnt_o=01 at cycle 0; mosi bits 1,0,1,0,0,1,0,1 across 8 rising edges; done_o=01 at cycle 37; rdata_o=0x000000A5; cs_no high again from cycle 37.
REQ-029 req_i=11 after reset -> requester 0 granted first, requester 1 granted in the first IDLE cycle after GAP; both still requesting -> requester 0 granted third.
REQ-030 Requester 1 requests alone twice with req_i[0]=0 -> both requests granted to requester 1 with no dead cycle beyond GAP.
REQ-031 len=3, wdata=0x12345678, miso tied 1 -> 32 rising edges; done_o at cycle 133; rdata_o=0xFFFFFFFF; mosi matches 0x12345678 MSB-first.
REQ-032 rst_i pulsed during SHIFT bit 5 -> cs_no=1 and clk=0 asynchronously; no done_o; a subsequent request completes normally.
REQ-033 req_i[1] pulsed high only during SHIFT of a requester-0 frame -> no gnt_o[1] and no extra frame.
